// File: rtl/bus_mapper_ws.sv
`default_nettype none
// ============================================================================
// Module   : bus_mapper_ws
// Purpose  : 64 KB window bank mapper with I/O-programmable CPU wait states.
// Revision : 1.0 - initial release
// ============================================================================
module bus_mapper_ws #(
  parameter int         NUM_WIN   = 4,
  parameter logic [3:0] WIN_BASE  = 4'h8,
  parameter int         BANK_BITS = 5,
  parameter logic [9:0] IO_BASE   = 10'h030,
  parameter logic [2:0] WS_RESET  = 3'd1
) (
  input  logic                   clk,
  input  logic                   RESET,
  input  logic                   cpu_clk_en,
  input  logic                   m_io,
  input  logic                   rd_n,
  input  logic                   wr_n,
  input  logic                   inta_n,
  input  logic [19:0]            addr_in,
  input  logic [7:0]             wdata,
  input  logic                   ext_rdy,
  output logic [15+BANK_BITS:0]  phys_addr,
  output logic                   in_window,
  output logic [7:0]             rdata,
  output logic                   rdata_oe,
  output logic                   ready
);

  localparam int WIDX = (NUM_WIN > 1) ? $clog2(NUM_WIN) : 1;
  localparam int PAW  = 16 + BANK_BITS;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  logic [BANK_BITS-1:0] bank_q [NUM_WIN];
  logic [2:0]           ws_win_q;
  logic [2:0]           ws_io_q;
  logic                 wr_q;
  logic                 cmd_q;
  state_t               state_q, state_d;
  logic [2:0]           cnt_q, cnt_d;

  logic [4:0]      seg;
  logic [3:0]      win_off;
  logic [WIDX-1:0] win_idx;
  logic            win_hit;
  logic            io_sel;
  logic [3:0]      io_off;
  logic [WIDX-1:0] io_idx;
  logic            io_is_bank;
  logic            io_is_wscfg;
  logic            wr_commit;
  logic            cmd;
  logic            start;
  logic [2:0]      ws_sel;

  // Window decode; 5-bit compare so WIN_BASE+NUM_WIN may reach 16.
  assign seg     = {1'b0, addr_in[19:16]};
  assign win_hit = m_io && (seg >= {1'b0, WIN_BASE})
                        && (seg < ({1'b0, WIN_BASE} + 5'(NUM_WIN)));
  assign win_off = addr_in[19:16] - WIN_BASE;

  generate
    if (NUM_WIN > 1) begin : g_idx_multi
      assign win_idx = win_off[WIDX-1:0];
      assign io_idx  = io_off[WIDX-1:0];
    end else begin : g_idx_single
      assign win_idx = '0;
      assign io_idx  = '0;
    end
  endgenerate

  assign phys_addr = win_hit ? {bank_q[win_idx], addr_in[15:0]} : PAW'(addr_in);
  assign in_window = win_hit;

  assign io_sel      = !m_io && (addr_in[9:4] == IO_BASE[9:4]);
  assign io_off      = addr_in[3:0];
  assign io_is_bank  = ({1'b0, io_off} < 5'(NUM_WIN));
  assign io_is_wscfg = (io_off == 4'd8);

  assign rdata_oe = !rd_n && io_sel;

  always_comb begin
    rdata = '0;
    if (rdata_oe) begin
      if (io_is_wscfg)
        rdata = {1'b0, ws_io_q, 1'b0, ws_win_q};
      else if (io_is_bank)
        rdata = 8'(bank_q[io_idx]);
    end
  end

  // Registers commit on the trailing (rising) edge of the write strobe.
  assign wr_commit = !wr_q && wr_n && io_sel;

  always_ff @(posedge clk) begin
    if (RESET) begin
      for (int i = 0; i < NUM_WIN; i++)
        bank_q[i] <= BANK_BITS'(i);
      ws_win_q <= WS_RESET;
      ws_io_q  <= WS_RESET;
      wr_q     <= 1'b1;
      cmd_q    <= 1'b0;
    end else begin
      wr_q  <= wr_n;
      cmd_q <= cmd;
      if (wr_commit) begin
        if (io_is_wscfg) begin
          ws_win_q <= wdata[2:0];
          ws_io_q  <= wdata[6:4];
        end else if (io_is_bank) begin
          bank_q[io_idx] <= BANK_BITS'(wdata);
        end
      end
    end
  end

  assign cmd   = !rd_n || !wr_n || !inta_n;
  assign start = cmd && !cmd_q;

  always_comb begin
    ws_sel = 3'd0;
    if (!inta_n || !m_io)
      ws_sel = ws_io_q;
    else if (win_hit)
      ws_sel = ws_win_q;
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready   = ext_rdy;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (ws_sel != 3'd0) begin
            state_d = S_WAIT;
            cnt_d   = ws_sel;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_WAIT: begin
        ready = 1'b0;
        if (!cmd) begin
          state_d = S_IDLE;
        end else if (cnt_q == 3'd0) begin
          state_d = S_DONE;
        end else if (cpu_clk_en) begin
          cnt_d = cnt_q - 3'd1;
          if (cnt_q == 3'd1)
            state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (!cmd)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_bus_mapper_ws.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_mapper_ws
// Purpose  : Randomized self-checking bench for bus_mapper_ws.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_mapper_ws;

  localparam int BB = 5;

  logic        clk = 1'b0;
  logic        RESET, cpu_clk_en, m_io, rd_n, wr_n, inta_n, ext_rdy;
  logic [19:0] addr_in;
  logic [7:0]  wdata;
  logic [20:0] phys_addr;
  logic        in_window, rdata_oe, ready;
  logic [7:0]  rdata;

  always #5 clk = ~clk;

  bus_mapper_ws #(
    .NUM_WIN(4), .WIN_BASE(4'h8), .BANK_BITS(BB), .IO_BASE(10'h030), .WS_RESET(3'd1)
  ) dut (
    .clk(clk), .RESET(RESET), .cpu_clk_en(cpu_clk_en), .m_io(m_io),
    .rd_n(rd_n), .wr_n(wr_n), .inta_n(inta_n), .addr_in(addr_in),
    .wdata(wdata), .ext_rdy(ext_rdy), .phys_addr(phys_addr),
    .in_window(in_window), .rdata(rdata), .rdata_oe(rdata_oe), .ready(ready)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference state: what the register block should hold right now.
  logic [BB-1:0] m_bank [4];
  logic [2:0]    m_wsw, m_wsi;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) m_bank[i] = BB'(i);
    m_wsw = 3'd1;
    m_wsi = 3'd1;
  endfunction

  function automatic bit exp_win(input bit mem, input logic [19:0] a);
    int seg;
    seg = int'(a[19:16]);
    return mem && seg >= 8 && seg <= 11;
  endfunction

  function automatic logic [20:0] exp_phys(input bit mem, input logic [19:0] a);
    int seg;
    seg = int'(a[19:16]);
    if (exp_win(mem, a)) return {m_bank[seg-8], a[15:0]};
    return {1'b0, a};
  endfunction

  function automatic bit port_hit(input logic [19:0] a);
    int p;
    p = int'(a[9:0]);
    return p >= 'h030 && p <= 'h03F;
  endfunction

  function automatic logic [7:0] exp_reg(input logic [19:0] a);
    int off;
    off = int'(a[9:0]) - 'h030;
    if (!port_hit(a)) return 8'h00;
    if (off < 4) return 8'(m_bank[off]);
    if (off == 8) return {1'b0, m_wsi, 1'b0, m_wsw};
    return 8'h00;
  endfunction

  function automatic int exp_ws(input bit mem, input logic [19:0] a);
    if (!mem) return int'(m_wsi);
    if (exp_win(mem, a)) return int'(m_wsw);
    return 0;
  endfunction

  // kind: 0 read, 1 write, 2 INTA. abort_after >= 0 releases the strobe once
  // that many cpu_clk_en strobes have been counted after the start edge.
  task automatic bus_cycle(input bit mem, input int kind, input logic [19:0] a,
                           input logic [7:0] d, input int abort_after, input bit rdy);
    int ws, seen, extra, off;
    bit cen_s;
    ws      = exp_ws(mem, a);
    m_io    = mem;
    addr_in = a;
    wdata   = d;
    ext_rdy = rdy;
    case (kind)
      0:       rd_n   = 1'b0;
      1:       wr_n   = 1'b0;
      default: inta_n = 1'b0;
    endcase
    #1;
    chk("phys_addr", 32'(phys_addr), 32'(exp_phys(mem, a)));
    chk("in_window", 32'(in_window), 32'(exp_win(mem, a)));
    chk("rdata_oe", 32'(rdata_oe), 32'((kind == 0) && !mem && port_hit(a)));
    if (kind == 0 && !mem) chk("rdata", 32'(rdata), 32'(exp_reg(a)));
    chk("ready_pre", 32'(ready), 32'(rdy));
    seen  = 0;
    extra = $urandom_range(0, 2);
    for (int i = 0; i < 200; i++) begin
      cen_s = cpu_clk_en;
      @(posedge clk);
      if (i > 0 && cen_s) seen++;
      #1;
      chk("ready_wait", 32'(ready), 32'(rdy && (seen >= ws)));
      cpu_clk_en = (i > 60) ? 1'b1 : ($urandom_range(0, 2) == 0);
      if (abort_after >= 0 && seen >= abort_after) break;
      if (seen >= ws) begin
        if (extra == 0) break;
        extra--;
      end
    end
    rd_n = 1'b1; wr_n = 1'b1; inta_n = 1'b1;
    @(posedge clk);
    #1;
    if (kind == 1 && !mem && port_hit(a)) begin
      off = int'(a[9:0]) - 'h030;
      if (off < 4) m_bank[off] = BB'(d);
      else if (off == 8) begin
        m_wsw = d[2:0];
        m_wsi = d[6:4];
      end
    end
    chk("ready_rel", 32'(ready), 32'(rdy));
    cpu_clk_en = ($urandom_range(0, 2) == 0);
  endtask

  initial begin
    logic [19:0] a;
    int r, ab;
    RESET = 1'b1; cpu_clk_en = 1'b0; m_io = 1'b0; rd_n = 1'b1; wr_n = 1'b1;
    inta_n = 1'b1; ext_rdy = 1'b1; addr_in = '0; wdata = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    RESET = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_oe", 32'(rdata_oe), 32'd0);

    // Identity map after reset, one window wait state.
    bus_cycle(1, 0, 20'h9ABCD, 8'h00, -1, 1'b1);
    chk("phys_9ABCD_const", 32'(exp_phys(1, 20'h9ABCD)), 32'h01ABCD);
    bus_cycle(0, 0, 20'h00038, 8'h00, -1, 1'b1);

    // Bank remap and non-window pass-through.
    bus_cycle(0, 1, 20'h00032, 8'h13, -1, 1'b1);
    bus_cycle(1, 0, 20'hA1234, 8'h00, -1, 1'b1);
    bus_cycle(1, 0, 20'h01234, 8'h00, -1, 1'b1);

    // ws_win=0, ws_io=3.
    bus_cycle(0, 1, 20'h00038, 8'h30, -1, 1'b1);
    bus_cycle(0, 0, 20'h00040, 8'h00, -1, 1'b1);
    bus_cycle(1, 0, 20'hB0000, 8'h00, -1, 1'b1);

    // Truncated bank readback and unmapped port inside the block.
    bus_cycle(0, 1, 20'h00031, 8'hFF, -1, 1'b1);
    bus_cycle(0, 0, 20'h00031, 8'h00, -1, 1'b1);
    bus_cycle(0, 0, 20'h0003C, 8'h00, -1, 1'b1);

    // Abort after one of three wait states, then a full-length cycle.
    bus_cycle(0, 0, 20'h00040, 8'h00, 1, 1'b1);
    bus_cycle(0, 0, 20'h00040, 8'h00, -1, 1'b1);
    bus_cycle(0, 2, 20'h00000, 8'h00, -1, 1'b1);

    // Reset while waiting.
    bus_cycle(0, 1, 20'h00038, 8'h22, -1, 1'b1);
    m_io = 1'b1; addr_in = 20'hA0000; rd_n = 1'b0; ext_rdy = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_wait_lo", 32'(ready), 32'd0);
    RESET = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_wait_hi", 32'(ready), 32'd1);
    RESET = 1'b0; rd_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    bus_cycle(0, 0, 20'h00032, 8'h00, -1, 1'b1);
    bus_cycle(0, 0, 20'h00038, 8'h00, -1, 1'b1);

    for (int t = 0; t < 150; t++) begin
      r  = $urandom_range(0, 9);
      ab = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 2) : -1;
      if (r < 4) begin
        a = 20'($urandom);
        if ($urandom_range(0, 1) == 1) a[19:16] = 4'(8 + $urandom_range(0, 3));
        bus_cycle(1, 0, a, 8'h00, ab, $urandom_range(0, 7) != 0);
      end else if (r < 9) begin
        a = '0;
        if ($urandom_range(0, 3) != 0) a[9:0] = 10'(10'h030 + $urandom_range(0, 15));
        else a[9:0] = 10'($urandom);
        bus_cycle(0, (r < 6) ? 0 : 1, a, 8'($urandom), ab, $urandom_range(0, 7) != 0);
      end else begin
        bus_cycle(0, 2, 20'($urandom), 8'h00, ab, $urandom_range(0, 7) != 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
